// File: rtl/expr_string_tx.sv
`default_nettype none
// ============================================================================
// expr_string_tx : buffers {digit, op} terms and streams them out as ASCII
// Revision 1.0
// ============================================================================
module expr_string_tx #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [3:0]               wr_digit,
  input  logic                     wr_op,
  input  logic                     start,
  input  logic                     out_ready,
  output logic [7:0]               out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIGIT = 2'd1;
  localparam logic [1:0] S_OP    = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    digit_q [DEPTH];
  logic [3:0]    digit_d [DEPTH];
  logic          op_q    [DEPTH];
  logic          op_d    [DEPTH];
  logic          wr_err_q, wr_err_d;

  logic w_idle;
  logic w_full;
  logic w_start_ok;
  logic w_wr_ok;
  logic w_last;

  assign w_idle     = (state_q == S_IDLE);
  assign w_full     = (count_q == CW'(DEPTH));
  assign w_start_ok = w_idle && start && (count_q != '0);
  // A start request in IDLE always takes precedence over a same-cycle write.
  assign w_wr_ok    = w_idle && wr_en && !start && !w_full && (wr_digit <= 4'd9);
  assign w_last     = ({1'b0, idx_q} == (count_q - CW'(1)));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_start_ok) state_d = S_DIGIT;
      S_DIGIT: if (out_ready) state_d = w_last ? S_DONE : S_OP;
      S_OP:    if (out_ready) state_d = S_DIGIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out       = 8'h00;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_DIGIT: begin
        out       = 8'h30 + {4'b0000, digit_q[idx_q]};
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      S_OP: begin
        out       = op_q[idx_q] ? 8'h2A : 8'h2B;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    idx_d    = idx_q;
    digit_d  = digit_q;
    op_d     = op_q;
    wr_err_d = wr_en && !w_wr_ok;
    if (w_wr_ok) begin
      digit_d[count_q[IW-1:0]] = wr_digit;
      op_d[count_q[IW-1:0]]    = wr_op;
      count_d                  = count_q + CW'(1);
    end
    if ((state_q == S_OP) && out_ready) begin
      idx_d = idx_q + IW'(1);
    end
    if (state_q == S_DONE) begin
      count_d = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q  <= '0;
      idx_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      idx_q    <= idx_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Buffer contents are only meaningful below count, so they need no reset.
  always_ff @(posedge clk) begin
    digit_q <= digit_d;
    op_q    <= op_d;
  end

  assign full   = w_full;
  assign count  = count_q;
  assign wr_err = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_expr_string_tx.sv
`default_nettype none
// ============================================================================
// tb_expr_string_tx : directed and randomized checks of expr_string_tx
// Revision 1.0
// ============================================================================
module tb_expr_string_tx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       clr;
  logic       wr_en;
  logic [3:0] wr_digit;
  logic       wr_op;
  logic       start;
  logic       out_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       full;
  logic [3:0] count;
  logic       wr_err;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  expr_string_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_digit(wr_digit), .wr_op(wr_op),
    .start(start), .out_ready(out_ready), .out(out), .out_valid(out_valid),
    .busy(busy), .done(done), .full(full), .count(count), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered terms, and the pending character string once started.
  logic [3:0] m_dig[$];
  logic       m_op[$];
  logic [7:0] m_chars[$];
  bit         m_emit = 1'b0;
  bit         m_done = 1'b0;
  bit         m_err  = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      m_dig.delete(); m_op.delete(); m_chars.delete();
      m_emit = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      bit err;
      err = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
        m_dig.delete(); m_op.delete();
        err = wr_en;
      end else if (m_emit) begin
        err = wr_en;
        if (out_ready) begin
          void'(m_chars.pop_front());
          if (m_chars.size() == 0) begin
            m_emit = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (start && m_dig.size() > 0) begin
        for (int i = 0; i < m_dig.size(); i++) begin
          m_chars.push_back(8'h30 + {4'h0, m_dig[i]});
          if (i < m_dig.size() - 1) m_chars.push_back(m_op[i] ? 8'h2A : 8'h2B);
        end
        m_emit = 1'b1;
        err = wr_en;
      end else if (wr_en) begin
        if (start || m_dig.size() == DEPTH || wr_digit > 4'd9) err = 1'b1;
        else begin
          m_dig.push_back(wr_digit);
          m_op.push_back(wr_op);
        end
      end
      m_err = err;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_out_valid", out_valid, m_emit);
      check("m_out", out, m_emit ? m_chars[0] : 8'h00);
      check("m_busy", busy, m_emit || m_done);
      check("m_done", done, m_done);
      check("m_count", count, m_dig.size());
      check("m_full", full, m_dig.size() == DEPTH);
      check("m_wr_err", wr_err, m_err);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_term(input int d, input bit o);
    wr_en = 1'b1; wr_digit = 4'(d); wr_op = o;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [7:0] lit5 [5];
  logic [7:0] lit7 [7];
  logic       rdy7 [7];
  logic [7:0] lit3 [3];

  initial begin
    clr = 1'b1; wr_en = 1'b0; wr_digit = 4'd0; wr_op = 1'b0;
    start = 1'b0; out_ready = 1'b0;
    step();
    check("rst_out", out, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_full", full, 1'b0);
    check("rst_wr_err", wr_err, 1'b0);
    cmp_en = 1'b1;
    clr = 1'b0;
    step();

    // Basic three-term stream
    out_ready = 1'b1;
    write_term(1, 0); write_term(2, 0); write_term(3, 1);
    check("t1_count", count, 4'd3);
    lit5 = '{8'h31, 8'h2B, 8'h32, 8'h2B, 8'h33};
    do_start();
    for (int i = 0; i < 5; i++) begin
      check("t1_valid", out_valid, 1'b1);
      check("t1_out", out, lit5[i]);
      step();
    end
    check("t1_done", done, 1'b1);
    step();
    check("t1_count_after", count, 4'd0);
    check("t1_busy_after", busy, 1'b0);

    // Stall in cycles 2-3
    write_term(1, 0); write_term(2, 0); write_term(3, 1);
    lit7 = '{8'h31, 8'h2B, 8'h2B, 8'h2B, 8'h32, 8'h2B, 8'h33};
    rdy7 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_start();
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy7[i];
      check("t2_valid", out_valid, 1'b1);
      check("t2_out", out, lit7[i]);
      step();
    end
    out_ready = 1'b1;
    check("t2_done", done, 1'b1);
    step();

    // Full buffer, overflow write, 15-character stream
    for (int j = 0; j < 8; j++) write_term(j, j[0]);
    check("t3_full", full, 1'b1);
    check("t3_count", count, 4'd8);
    write_term(9, 0);
    check("t3_ovf_err", wr_err, 1'b1);
    check("t3_ovf_count", count, 4'd8);
    do_start();
    for (int j = 0; j < 15; j++) begin
      check("t3_out", out, (j % 2 == 0) ? 32'h30 + j / 2 : (((j / 2) % 2 == 1) ? 32'h2A : 32'h2B));
      step();
    end
    check("t3_done", done, 1'b1);
    step();

    // Bad digit and empty start
    write_term(10, 0);
    check("t4_err", wr_err, 1'b1);
    check("t4_count", count, 4'd0);
    do_start();
    check("t4_busy", busy, 1'b0);
    check("t4_valid", out_valid, 1'b0);
    step();
    check("t4_busy2", busy, 1'b0);

    // Clear mid-emission
    write_term(1, 0); write_term(2, 0); write_term(3, 1);
    do_start();
    check("t5_c1", out, 8'h31);
    step();
    check("t5_c2", out, 8'h2B);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t5_valid", out_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_count", count, 4'd0);
    check("t5_done", done, 1'b0);
    step();
    check("t5_done2", done, 1'b0);
    write_term(4, 0);
    do_start();
    check("t5_new", out, 8'h34);
    step();
    check("t5_new_done", done, 1'b1);
    step();

    // Back-to-back stream
    write_term(5, 1); write_term(7, 0);
    lit3 = '{8'h35, 8'h2A, 8'h37};
    do_start();
    for (int i = 0; i < 3; i++) begin
      check("t6_out", out, lit3[i]);
      step();
    end
    check("t6_done", done, 1'b1);
    step();

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      clr       = ($urandom_range(0, 249) == 0);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_digit  = 4'($urandom_range(0, 11));
      wr_op     = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if (wr_en && start && m_dig.size() == 0) start = 1'b0;
      step();
    end
    clr = 1'b0; wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/expr_string_tx.md
# expr_string_tx

Transmitter for the ASCII arithmetic-expression character stream consumed by the expression recognizer. It buffers up to DEPTH terms (one decimal digit plus a following operator) and serializes them as one 8-bit ASCII character per accepted transfer: digit, operator, digit, …, digit. It sits upstream of the recognizer's `in` port and serves as a stimulus generator and loopback source for that checker.

## Interface
- DEPTH, 8, term buffer capacity; power of two, ≥2
- clk  input  1  system clock, rising edge
- clr  input  1  synchronous active-high reset
- wr_en  input  1  write one term into the buffer
- wr_digit  input  4  term value, valid range 0–9
- wr_op  input  1  operator after this term: 0 = '+' (0x2B), 1 = '*' (0x2A)
- start  input  1  begin emission of the buffered expression
- out_ready  input  1  downstream accepts `out` this cycle
- out  output  8  ASCII character
- out_valid  output  1  `out` holds a valid character
- busy  output  1  emission in progress
- done  output  1  one-cycle pulse after the last character is accepted
- full  output  1  count == DEPTH
- count  output  clog2(DEPTH)+1  number of buffered terms
- wr_err  output  1  one-cycle pulse when a write is rejected

## Operation
- Reset (`clr`=1 at an edge): all outputs are 0, `out`=0x00, state IDLE, buffer emptied, read index 0. This holds regardless of state, including mid-emission.
- Writes are accepted only in IDLE with `full`=0 and `wr_digit` ≤ 9. An accepted write stores {digit, op} at index `count`, and `count` increments by 1.
- Any rejected write (busy, full, or digit > 9) leaves the buffer unchanged and pulses `wr_err` on the next cycle.
- `start` is honoured only in IDLE with `count` > 0. Otherwise it is ignored, with no error.
- If `start` and `wr_en` are both high in IDLE, `start` wins. The write is rejected and `wr_err` pulses.
- State machine:
  - IDLE → DIGIT on an honoured `start`.
  - DIGIT: `out` = 0x30 + digit[idx]. When `out_ready`=1: if idx == count−1, go to DONE; else go to OP.
  - OP: `out` = '+' or '*' per op[idx]. When `out_ready`=1, idx increments and the state goes to DIGIT.
  - DONE: `done`=1, `out_valid`=0. Then → IDLE, `count` := 0, idx := 0.
- The operator stored with the last term is never emitted.
- `out_valid`=1 exactly in DIGIT and OP. While `out_valid`=1 and `out_ready`=0, `out` and the state stay stable.
- `busy`=1 in DIGIT, OP and DONE.
- In IDLE, `out`=0x00.

## Timing
- `start` sampled at edge 0 → first character is valid in cycle 1 (one-cycle latency).
- With `out_ready` held high and N terms: characters appear in cycles 1 … 2N−1, `done`=1 in cycle 2N, IDLE with `count`=0 from cycle 2N+1.
- Each low cycle of `out_ready` while `out_valid`=1 adds exactly one cycle.
- A write accepted at edge k is reflected in `count` and `full` in cycle k+1.
- `clr` asserted at any edge takes effect that edge. The following cycle shows `out_valid`=0, `busy`=0, `count`=0, and `done` is not pulsed.

## Test plan
- Write (1,+),(2,+),(3,*), then start with `out_ready`=1 → `out` = "1","+","2","+","3" (0x31,0x2B,0x32,0x2B,0x33) in cycles 1–5, `done` in cycle 6, `count`=0 after.
- Same buffer, `out_ready` low in cycles 2–3 → `out` holds 0x2B with `out_valid`=1 across the stall, full sequence completes, `done` in cycle 8.
- Write 8 terms with DEPTH=8 → `full`=1, `count`=8. A ninth write → `wr_err` pulse, `count` stays 8. Start → 15 characters, `done` in cycle 16.
- Write digit 10 → `wr_err` pulse, `count` unchanged. `start` with `count`=0 → `busy` and `out_valid` remain 0.
- Start a 3-term stream and assert `clr` in cycle 3 → cycle 4 shows `out_valid`=0, `busy`=0, `count`=0, no `done` pulse. A new write plus start then emits only the new term.
- Back-to-back: after `done`, write (5,*),(7,+) and start → `out` = 0x35, 0x2A, 0x37.
